i_cache: RTL and testbench
==========================

I_CACHE -- requirements
Module: i_cache

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, instruction word-address width.
REQ-002 Parameter DATA_WIDTH, default 32, instruction width.
REQ-003 Parameter INDEX_WIDTH, default 6, set-index bits (64 lines).
REQ-004 Parameter OFFSET_WIDTH, default 2, word-in-line bits (4 words/line); tag = ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH bits.
REQ-005 i_clock  in  1  clock; all state on rising edge.
REQ-006 i_reset  in  1  reset, synchronous, active-high.
REQ-007 i_addr  in  ADDR_WIDTH  word address of requested instruction.
REQ-008 i_rd  in  1  read request, single-cycle pulse allowed.
REQ-009 o_inst  out  DATA_WIDTH  instruction, valid when o_hit=1.
REQ-010 o_busy  out  1  line fill in progress.
REQ-011 o_hit  out  1  o_inst valid this cycle.
REQ-012 o_mem_addr  out  ADDR_WIDTH  backing-memory word address.
REQ-013 i_mem_data  in  DATA_WIDTH  backing-memory data, combinational (same-cycle) response to o_mem_addr.

Function
REQ-014 Direct-mapped; address split {tag, index, offset}, offset in LSBs; per line: valid bit, tag, 4 data words.
REQ-015 States IDLE, FILL, DONE.
REQ-016 IDLE: o_hit = i_rd & valid[index] & (tag[index]==addr tag), combinational; o_inst = addressed word on hit, else 0; o_busy=0; o_mem_addr=0.
REQ-017 Hit latency 0 cycles; hit changes no state; stay IDLE.
REQ-018 IDLE with i_rd=1 and miss: latch i_addr, o_hit=0 that cycle, next state FILL, word counter=0.
REQ-019 FILL: o_busy=1, o_hit=0, o_inst=0; o_mem_addr = {latched tag, latched index, counter}; i_mem_data written to that word; counter+1 each cycle; exactly 4 cycles, offsets 0,1,2,3.
REQ-020 On last FILL cycle: write tag, set valid for latched index, next state DONE.
REQ-021 DONE (one cycle): o_busy=0, o_hit=1, o_inst = filled word at latched offset; next state IDLE.
REQ-022 Miss latency: request cycle T, fill T+1..T+4, o_hit=1 at T+5.
REQ-023 i_rd in FILL or DONE ignored, not queued; i_addr ignored outside IDLE.
REQ-024 Conflicting tag on same index: fill overwrites line (evicts previous tag).
REQ-025 Offset within a line does not affect hit; any word of a valid line hits.
REQ-026 i_rd=0: no state change, o_hit=0.

Reset
REQ-027 i_reset=1 at clock edge: state IDLE, counter 0, all valid bits cleared; data/tag arrays need not be cleared.
REQ-028 During/after reset: o_busy=0, o_hit=0, o_inst=0, o_mem_addr=0.
REQ-029 Reset mid-fill aborts fill; line being filled remains invalid.
REQ-030 Reset has priority over i_rd in same cycle.

Verification
Backing memory for all scenarios: word at address a = a zero-extended to 32 bits.
REQ-031 After reset, i_rd pulse addr 0x010 -> o_hit=0 in request cycle; o_busy=1 for 4 cycles with o_mem_addr 0x010,0x011,0x012,0x013; then o_hit=1, o_inst=0x00000010 for one cycle.
REQ-032 Then i_rd 0x010, later 0x012, later 0x011 -> each o_hit=1 same cycle, o_inst=0x010/0x012/0x011, o_busy stays 0.
REQ-033 i_rd 0x017 -> miss, fill addresses 0x014..0x017, o_inst=0x00000017 at T+5; line at index 4 still hits.
REQ-034 i_rd 0xF11 (same index as 0x011) -> miss, fill 0xF10..0xF13, o_inst=0x00000F11; then i_rd 0x011 -> miss and refill 0x010..0x013, o_inst=0x00000011; then i_rd 0xF10 -> miss again, o_inst=0x00000F10.
REQ-035 i_rd pulse during FILL with other address -> ignored; no extra fill; DONE returns original word.
REQ-036 Reset asserted during FILL cycle 2 -> o_busy=0 next cycle; subsequent i_rd same address misses and performs full 4-word fill.

Source files
------------

// File: rtl/i_cache.sv
// Direct-mapped instruction cache with 4-word lines.
// Hits return in the same cycle; misses fill a line over four cycles.
module i_cache #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_rd,
  output logic [DATA_WIDTH-1:0] o_inst,
  output logic                  o_busy,
  output logic                  o_hit,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int LINE_AW   = INDEX_WIDTH + OFFSET_WIDTH;
  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int WORDS     = 1 << LINE_AW;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   req_q;
  logic [LINES-1:0]        valid_q;
  logic [TAG_WIDTH-1:0]    tag_mem  [LINES];
  logic [DATA_WIDTH-1:0]   data_mem [WORDS];

  logic [TAG_WIDTH-1:0]   in_tag, req_tag;
  logic [INDEX_WIDTH-1:0] in_idx, req_idx;
  logic [LINE_AW-1:0]     in_word, req_word;
  logic                   lookup_hit;
  logic                   fill_last;
  logic                   fill_we;
  logic                   latch;

  assign in_tag   = i_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign in_idx   = i_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign in_word  = i_addr[LINE_AW-1:0];
  assign req_tag  = req_q[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign req_idx  = req_q[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_word = req_q[LINE_AW-1:0];

  assign lookup_hit = valid_q[in_idx] && (tag_mem[in_idx] == in_tag);
  assign fill_last  = (cnt_q == '1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch      = 1'b0;
    fill_we    = 1'b0;
    o_hit      = 1'b0;
    o_inst     = '0;
    o_busy     = 1'b0;
    o_mem_addr = '0;
    unique case (state_q)
      IDLE: begin
        if (i_rd) begin
          if (lookup_hit) begin
            o_hit  = 1'b1;
            o_inst = data_mem[in_word];
          end else begin
            latch   = 1'b1;
            cnt_d   = '0;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        o_busy     = 1'b1;
        o_mem_addr = {req_tag, req_idx, cnt_q};
        fill_we    = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (fill_last) state_d = DONE;
      end
      DONE: begin
        o_hit   = 1'b1;
        o_inst  = data_mem[req_word];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset wins over everything, including a same-cycle request.
    if (i_reset) begin
      latch      = 1'b0;
      fill_we    = 1'b0;
      o_hit      = 1'b0;
      o_inst     = '0;
      o_busy     = 1'b0;
      o_mem_addr = '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) req_q <= i_addr;
      if (fill_we && fill_last) valid_q[req_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (fill_we) begin
      data_mem[{req_idx, cnt_q}] <= i_mem_data;
      if (fill_last) tag_mem[req_idx] <= req_tag;
    end
  end

endmodule

// File: tb/tb_i_cache.sv
// Bench for i_cache: directed scenarios plus random accesses
// against a line-level valid/tag model; memory word a holds a.
module tb_i_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] addr;
  logic        rd;
  logic [31:0] inst;
  logic        busy;
  logic        hit;
  logic [11:0] mem_addr;
  logic [31:0] mem_data;

  int errors = 0;
  int checks = 0;

  bit       m_valid [64];
  bit [3:0] m_tag   [64];

  always #5 clk = ~clk;

  assign mem_data = {20'd0, mem_addr};

  i_cache dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_addr    (addr),
    .i_rd      (rd),
    .o_inst    (inst),
    .o_busy    (busy),
    .o_hit     (hit),
    .o_mem_addr(mem_addr),
    .i_mem_data(mem_data)
  );

  function automatic bit m_hit(input logic [11:0] a);
    return m_valid[a[7:2]] && (m_tag[a[7:2]] == a[11:8]);
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endfunction

  task automatic access(input logic [11:0] a, input bit poke,
                        input logic [11:0] paddr);
    bit exp_hit;
    logic [11:0] ea;
    @(negedge clk);
    rd = 1'b1;
    addr = a;
    #1;
    exp_hit = m_hit(a);
    checks++;
    if (hit !== exp_hit) begin
      errors++;
      $display("FAIL req_hit a=%h got=%b want=%b", a, hit, exp_hit);
    end
    if (exp_hit) begin
      checks++;
      if (inst !== {20'd0, a} || busy !== 1'b0 || mem_addr !== 12'd0) begin
        errors++;
        $display("FAIL hit_data a=%h got=%h busy=%b want=%h",
                 a, inst, busy, {20'd0, a});
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        rd = poke && (k == 1);
        addr = poke ? paddr : 12'($urandom);
        #1;
        ea = {a[11:2], 2'(k)};
        checks++;
        if (busy !== 1'b1 || hit !== 1'b0 || mem_addr !== ea) begin
          errors++;
          $display("FAIL fill a=%h k=%0d got=%h/%b/%b want=%h/1/0",
                   a, k, mem_addr, busy, hit, ea);
        end
      end
      @(negedge clk);
      rd = 1'b0;
      #1;
      checks++;
      if (hit !== 1'b1 || busy !== 1'b0 || inst !== {20'd0, a}) begin
        errors++;
        $display("FAIL done a=%h got=%h/%b/%b want=%h/1/0",
                 a, inst, hit, busy, {20'd0, a});
      end
      m_valid[a[7:2]] = 1'b1;
      m_tag[a[7:2]] = a[11:8];
    end
    @(negedge clk);
    rd = 1'b0;
    #1;
    checks++;
    if (hit !== 1'b0 || busy !== 1'b0 || inst !== 32'd0) begin
      errors++;
      $display("FAIL idle a=%h got=%h/%b/%b want=0/0/0",
               a, inst, hit, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd = 1'b1;
    addr = 12'h010;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({hit, busy} !== 2'b00 || inst !== 32'd0 ||
          mem_addr !== 12'd0) begin
        errors++;
        $display("FAIL reset got=%b%b/%h/%h want=00/0/0",
                 hit, busy, inst, mem_addr);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    rd = 1'b0;
    m_clear();
  endtask

  task automatic test_first_fill();
    access(12'h010, 1'b0, 12'h000);
  endtask

  task automatic test_hits();
    access(12'h010, 1'b0, 12'h000);
    access(12'h012, 1'b0, 12'h000);
    access(12'h011, 1'b0, 12'h000);
  endtask

  task automatic test_adjacent();
    access(12'h017, 1'b0, 12'h000);
    access(12'h013, 1'b0, 12'h000);
  endtask

  task automatic test_conflict();
    access(12'hF11, 1'b0, 12'h000);
    access(12'h011, 1'b0, 12'h000);
    access(12'hF10, 1'b0, 12'h000);
  endtask

  task automatic test_ignore();
    access(12'h020, 1'b1, 12'h555);
    access(12'h555, 1'b0, 12'h000);
  endtask

  task automatic test_reset_mid_fill();
    @(negedge clk);
    rd = 1'b1;
    addr = 12'h030;
    #1;
    checks++;
    if (hit !== 1'b0) begin
      errors++;
      $display("FAIL mid_req got=%b want=0", hit);
    end
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || hit !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got=%b%b want=00", busy, hit);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hit !== 1'b0 || mem_addr !== 12'd0) begin
      errors++;
      $display("FAIL mid_after got=%b%b/%h want=00/0",
               busy, hit, mem_addr);
    end
    m_clear();
    access(12'h030, 1'b0, 12'h000);
  endtask

  task automatic test_random();
    logic [11:0] a;
    for (int n = 0; n < 80; n++) begin
      a = {2'b00, 2'($urandom), 4'd0, 2'($urandom), 2'($urandom)};
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        rd = 1'b0;
        addr = a;
        #1;
        checks++;
        if (hit !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL rd_low a=%h got=%b%b want=00", a, hit, busy);
        end
      end else begin
        access(a, 1'($urandom), 12'($urandom));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    rd = 1'b0;
    addr = '0;
    m_clear();
    test_reset();
    test_first_fill();
    test_hits();
    test_adjacent();
    test_conflict();
    test_ignore();
    test_reset_mid_fill();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
